// File: rtl/cam_dvp_tx.sv
// OV7670-style DVP transmitter producing RGB565 test frames.
// Drives pclk/vsync/href/din so the capture path runs without a sensor.
module cam_dvp_tx #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   parameter int PCLK_DIV    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   input  logic [15:0] solid_color,
   output logic        cam_pclk,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_din,
   output logic        frame_start,
   output logic [15:0] frame_count,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_VBACK,
      S_ACTIVE,
      S_VFRONT
   } state_t;

   localparam int          L        = 2 * H_ACTIVE + H_BLANK;
   localparam logic [15:0] L_LAST   = 16'(L - 1);
   localparam logic [15:0] DIV_LAST = 16'(PCLK_DIV - 1);
   localparam logic [15:0] HREF_END = 16'(2 * H_ACTIVE);
   localparam logic [15:0] BAR_W    = 16'(H_ACTIVE / 8);

   state_t      state_q, state_d;
   logic [15:0] div_q, div_d;
   logic        pclk_q, pclk_d;
   logic [15:0] h_q, h_d;
   logic [15:0] v_q, v_d;
   logic [1:0]  pat_q, pat_d;
   logic [15:0] solid_q, solid_d;
   logic [15:0] fc_q, fc_d;
   logic        vs_q, vs_d;
   logic        href_q, href_d;
   logic [7:0]  din_q, din_d;
   logic        fs_q, fs_d;
   logic        busy_q, busy_d;

   logic        slot;
   logic        start;
   logic [15:0] x;
   logic [15:0] bar;
   logic [15:0] pix;

   function automatic logic [15:0] last_line(state_t s);
      logic [15:0] r;
      r = 16'd0;
      case (s)
         S_VSYNC:  r = 16'(VSYNC_LINES - 1);
         S_VBACK:  r = 16'(V_BACK - 1);
         S_ACTIVE: r = 16'(V_ACTIVE - 1);
         S_VFRONT: r = 16'(V_FRONT - 1);
         default:  r = 16'd0;
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      pclk_d  = pclk_q;
      h_d     = h_q;
      v_d     = v_q;
      pat_d   = pat_q;
      solid_d = solid_q;
      fc_d    = fc_q;
      vs_d    = vs_q;
      href_d  = href_q;
      din_d   = din_q;
      fs_d    = 1'b0;
      busy_d  = busy_q;
      start   = 1'b0;
      x       = 16'd0;
      bar     = 16'd0;
      pix     = 16'd0;

      slot = pclk_q && (div_q == DIV_LAST);

      if (div_q == DIV_LAST) begin
         div_d  = 16'd0;
         pclk_d = ~pclk_q;
      end else begin
         div_d = div_q + 16'd1;
      end

      // Slot update: DVP outputs move only as pclk falls
      if (slot) begin
         if (state_q == S_IDLE) begin
            start = enable;
         end else if (h_q != L_LAST) begin
            h_d = h_q + 16'd1;
         end else begin
            h_d = 16'd0;
            if (v_q != last_line(state_q)) begin
               v_d = v_q + 16'd1;
            end else begin
               v_d = 16'd0;
               case (state_q)
                  S_VSYNC:  state_d = (V_BACK == 0) ? S_ACTIVE : S_VBACK;
                  S_VBACK:  state_d = S_ACTIVE;
                  S_ACTIVE: state_d = S_VFRONT;
                  S_VFRONT: begin
                     fc_d    = fc_q + 16'd1;
                     state_d = S_IDLE;
                     start   = enable;
                  end
                  default:  state_d = S_IDLE;
               endcase
            end
         end

         if (start) begin
            state_d = S_VSYNC;
            h_d     = 16'd0;
            v_d     = 16'd0;
            pat_d   = pattern_sel;
            solid_d = solid_color;
            fs_d    = 1'b1;
         end

         x   = {1'b0, h_d[15:1]};
         bar = x / BAR_W;
         case (pat_d)
            2'd0: begin
               case (bar)
                  16'd0:   pix = 16'hFFFF;
                  16'd1:   pix = 16'hFFE0;
                  16'd2:   pix = 16'h07FF;
                  16'd3:   pix = 16'h07E0;
                  16'd4:   pix = 16'hF81F;
                  16'd5:   pix = 16'hF800;
                  16'd6:   pix = 16'h001F;
                  default: pix = 16'h0000;
               endcase
            end
            2'd1:    pix = {v_d[7:0], x[7:0]};
            2'd2:    pix = (x[5] ^ v_d[5] ^ fc_q[0]) ? 16'hFFFF : 16'h0000;
            default: pix = solid_d;
         endcase

         vs_d   = (state_d == S_VSYNC);
         href_d = (state_d == S_ACTIVE) && (h_d < HREF_END);
         din_d  = href_d ? (h_d[0] ? pix[7:0] : pix[15:8]) : 8'd0;
         busy_d = (state_d != S_IDLE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         div_q   <= 16'd0;
         pclk_q  <= 1'b0;
         h_q     <= 16'd0;
         v_q     <= 16'd0;
         pat_q   <= 2'd0;
         solid_q <= 16'd0;
         fc_q    <= 16'd0;
         vs_q    <= 1'b0;
         href_q  <= 1'b0;
         din_q   <= 8'd0;
         fs_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         pclk_q  <= pclk_d;
         h_q     <= h_d;
         v_q     <= v_d;
         pat_q   <= pat_d;
         solid_q <= solid_d;
         fc_q    <= fc_d;
         vs_q    <= vs_d;
         href_q  <= href_d;
         din_q   <= din_d;
         fs_q    <= fs_d;
         busy_q  <= busy_d;
      end
   end

   assign cam_pclk    = pclk_q;
   assign cam_vsync   = vs_q;
   assign cam_href    = href_q;
   assign cam_din     = din_q;
   assign frame_start = fs_q;
   assign frame_count = fc_q;
   assign busy        = busy_q;

endmodule
